// File: rtl/idct_1d.sv
// idct_1d: serial 8-point one-dimensional inverse DCT.
//
// Eight signed 12-bit coefficients X[0..7] are loaded one per load command.
// The block then runs 64 multiply-accumulate cycles, one (n, k) pair per
// cycle, against a signed 8-bit cosine table. Each finished sum is rounded,
// scaled by 1/256, clamped to 0..255 and stored. The eight samples are then
// released one per output/advance command.
//
// Ports:
//   clk       rising-edge clock for all state
//   rstn      asynchronous active-low reset
//   state     command: 00 hold, 01 load, 10 output/advance, 11 abort
//   in        signed DCT coefficient, X[0] first
//   out       reconstructed unsigned sample x[n] (registered)
//   out_valid high for exactly the cycles in which out carries a new sample
module idct_1d (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  state,
    input  logic [11:0] in,
    output logic [7:0]  out,
    output logic        out_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CALC = 2'b10,
        ST_OUT  = 2'b11
    } fsm_t;

    typedef enum logic [1:0] {
        CMD_HOLD  = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_OUT   = 2'b10,
        CMD_ABORT = 2'b11
    } cmd_t;

    cmd_t               cmd;
    fsm_t               fsm;
    logic [2:0]         idx;
    logic [5:0]         cnt;      // CALC step: n = cnt[5:3], k = cnt[2:0]
    logic signed [22:0] acc;

    logic signed [11:0] xbuf [8];
    logic [7:0]         rbuf [8];

    logic [2:0]         k_i;
    logic [2:0]         n_i;
    logic signed [7:0]  q;
    logic signed [19:0] prod;
    logic signed [22:0] acc_next;
    logic signed [22:0] rnd_sum;
    logic signed [22:0] shifted;
    logic [7:0]         reduced;

    assign cmd = cmd_t'(state);
    assign k_i = cnt[2:0];
    assign n_i = cnt[5:3];

    // Q[k][n] = round(128*cos((2n+1)*k*pi/16)), Q[0][n] = 91.
    // The angle (2n+1)*k is taken mod 32 (units of pi/16) and folded into
    // the first quadrant; a fold past pi/2 flips the sign. For k != 0 the
    // product is odd*k with k < 8, so it never lands on 0 or 16.
    function automatic logic signed [7:0] coef(input logic [2:0] k,
                                               input logic [2:0] n);
        logic [6:0] ang;
        logic [4:0] m;
        logic [4:0] f;
        logic       neg;
        logic [7:0] mag;
        logic [7:0] res;
        ang = {3'b000, n, 1'b1} * {4'b0000, k};
        m   = ang[4:0];
        f   = (m > 5'd16) ? (5'd0 - m) : m;
        neg = (f > 5'd8);
        if (neg) f = 5'd16 - f;
        case (f)
            5'd1:    mag = 8'd126;
            5'd2:    mag = 8'd118;
            5'd3:    mag = 8'd106;
            5'd4:    mag = 8'd91;
            5'd5:    mag = 8'd71;
            5'd6:    mag = 8'd49;
            5'd7:    mag = 8'd25;
            default: mag = 8'd0;
        endcase
        res = neg ? (8'd0 - mag) : mag;
        if (k == 3'd0) res = 8'd91;
        return $signed(res);
    endfunction

    always_comb begin
        q        = coef(k_i, n_i);
        prod     = 20'(q) * 20'(xbuf[k_i]);
        acc_next = acc + $signed({{3{prod[19]}}, prod});
        rnd_sum  = acc_next + 23'sd128;
        shifted  = rnd_sum >>> 8;
        if (shifted < 0)
            reduced = '0;
        else if (shifted > 23'sd255)
            reduced = '1;
        else
            reduced = shifted[7:0];
    end

    // Control, counters, accumulator and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm       <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (cmd == CMD_ABORT) begin
            fsm       <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    out       <= '0;
                    out_valid <= 1'b0;
                    idx       <= '0;
                    if (cmd == CMD_LOAD) begin
                        idx <= 3'd1;
                        fsm <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    out_valid <= 1'b0;
                    if (cmd == CMD_LOAD) begin
                        if (idx == 3'd7) begin
                            fsm <= ST_CALC;
                            idx <= '0;
                            cnt <= '0;
                            acc <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                ST_CALC: begin
                    out_valid <= 1'b0;
                    cnt       <= cnt + 6'd1;
                    // The finished sum leaves through the result buffer, so
                    // the accumulator restarts at zero for the next n.
                    acc <= (k_i == 3'd7) ? '0 : acc_next;
                    if (cnt == 6'd63) begin
                        fsm <= ST_OUT;
                        idx <= '0;
                    end
                end
                ST_OUT: begin
                    if (cmd == CMD_OUT) begin
                        out       <= rbuf[idx];
                        out_valid <= 1'b1;
                        if (idx == 3'd7) begin
                            fsm <= ST_IDLE;
                            idx <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm <= ST_IDLE;
                    idx <= '0;
                end
            endcase
        end
    end

    // Data buffers carry no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (cmd == CMD_LOAD && fsm == ST_IDLE)
            xbuf[0] <= in;
        else if (cmd == CMD_LOAD && fsm == ST_LOAD)
            xbuf[idx] <= in;
        if (fsm == ST_CALC && cmd != CMD_ABORT && k_i == 3'd7)
            rbuf[n_i] <= reduced;
    end

endmodule

// File: tb/tb_idct_1d.sv
// tb_idct_1d: scoreboard bench for idct_1d. Expected samples come from a
// floating-point-derived cosine table model and are queued when a block is
// loaded; a negedge monitor pops and compares on every out_valid.
module tb_idct_1d;

    typedef logic signed [11:0] blk_t [8];

    localparam real PI = 3.14159265358979323846;

    logic        clk;
    logic        rstn;
    logic [1:0]  state;
    logic [11:0] in;
    logic [7:0]  out;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cap = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int exp_q[$];

    idct_1d dut (
        .clk       (clk),
        .rstn      (rstn),
        .state     (state),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input blk_t b);
        for (int n = 0; n < 8; n++) begin
            int s;
            int r;
            s = 0;
            for (int k = 0; k < 8; k++) begin
                int qv;
                if (k == 0) qv = 91;
                else qv = int'(128.0 * $cos(real'((2 * n + 1) * k) * PI / 16.0));
                s += qv * int'(b[k]);
            end
            r = (s + 128) >>> 8;
            if (r < 0) r = 0;
            if (r > 255) r = 255;
            exp_q.push_back(r);
        end
    endfunction

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) chk("extra_sample", 32'(out_valid), 0);
            else chk("sample", 32'(out), 32'(exp_q.pop_front()));
        end
    end

    // Load one block, then drain its eight samples.
    task automatic run_block(input blk_t b, input int pause_at, input int pause_len,
                             input int stall_at, input bit rnd);
        int seen;
        int n;
        bit stalled;
        logic [7:0] held;
        first_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            if (rnd) begin
                while ($urandom_range(3) == 0) begin
                    state = ($urandom_range(1) == 0) ? 2'b00 : 2'b10;
                    tick();
                end
            end
            state = 2'b01;
            in = b[k];
            tick();
            if (k == pause_at) begin
                repeat (pause_len) begin
                    state = 2'b00;
                    in = 12'hABC;
                    tick();
                end
            end
        end
        cap = cyc;
        model(b);
        seen = 0;
        n = 0;
        stalled = 1'b0;
        while (seen < 8 && n < 400) begin
            if (rnd && $urandom_range(3) == 0)
                state = ($urandom_range(1) == 0) ? 2'b00 : 2'b01;
            else
                state = 2'b10;
            in = 12'($urandom_range(4095));
            tick();
            n++;
            if (out_valid === 1'b1) seen++;
            if (seen == stall_at && !stalled) begin
                stalled = 1'b1;
                held = out;
                repeat (3) begin
                    state = 2'b00;
                    tick();
                    n++;
                    chk("stall_valid", 32'(out_valid), 0);
                    chk("stall_hold", 32'(out), 32'(held));
                end
            end
        end
        if (seen < 8) begin
            chk("timeout_samples", seen, 8);
            exp_q.delete();
        end
        state = 2'b00;
        tick();
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_out", 32'(out), 0);
        chk("idle_valid", 32'(out_valid), 0);
    endtask

    task automatic reset_test(input int wait_cycles, input int post_cycles);
        blk_t b;
        b = '{default: '0};
        b[0] = 12'sd362;
        for (int k = 0; k < 8; k++) begin
            state = 2'b01;
            in = b[k];
            tick();
        end
        model(b);
        state = 2'b10;
        repeat (wait_cycles) tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_out", 32'(out), 0);
        chk("rst_valid", 32'(out_valid), 0);
        exp_q.delete();
        #3;
        rstn = 1'b1;
        if (post_cycles > 0) begin
            repeat (post_cycles) tick();
            chk("post_rst_valid", 32'(out_valid), 0);
            chk("post_rst_out", 32'(out), 0);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_timeout got %0d expected %0d", cyc, 0);
        $fatal(1, "simulation time limit");
    end

    initial begin
        blk_t dc;
        blk_t hi;
        blk_t neg;
        blk_t ac1;
        blk_t rb;

        dc  = '{default: '0};
        hi  = '{default: '0};
        neg = '{default: '0};
        ac1 = '{default: '0};
        dc[0]  = 12'sd362;
        hi[0]  = 12'sd2047;
        neg[0] = -12'sd100;
        ac1[1] = 12'sd100;

        rstn  = 1'b0;
        state = 2'b01;
        in    = 12'h123;
        #3;
        chk("reset_out", 32'(out), 0);
        chk("reset_valid", 32'(out_valid), 0);
        @(negedge clk);
        @(negedge clk);
        state = 2'b00;
        rstn  = 1'b1;

        // DC block with output held on: exact latency from the X[7] edge.
        run_block(dc, -1, 0, -1, 1'b0);
        chk("latency_first", first_cyc - cap, 65);
        chk("latency_last", last_cyc - cap, 72);

        run_block(hi, -1, 0, -1, 1'b0);
        run_block(neg, -1, 0, -1, 1'b0);
        run_block(ac1, -1, 0, -1, 1'b0);

        // Load paused for 5 cycles after X[2].
        rb = '{default: '0};
        for (int k = 0; k < 8; k++) rb[k] = 12'($urandom_range(4095));
        run_block(rb, 2, 5, -1, 1'b0);

        // Abort after three loads, then a clean DC block.
        for (int k = 0; k < 3; k++) begin
            state = 2'b01;
            in = 12'($urandom_range(4095));
            tick();
        end
        state = 2'b11;
        tick();
        chk("abort_out", 32'(out), 0);
        chk("abort_valid", 32'(out_valid), 0);
        run_block(dc, -1, 0, -1, 1'b0);

        // Output stall between x[3] and x[4].
        run_block(ac1, -1, 0, 4, 1'b0);

        // Reset during OUT (out nonzero), then quiet after release.
        reset_test(67, 50);
        // Reset during CALC; the first edge after release loads a new block.
        reset_test(20, 0);
        run_block(ac1, -1, 0, -1, 1'b0);

        // Random regression with random pauses and stalls.
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 8; k++) rb[k] = 12'($urandom_range(4095));
            run_block(rb, -1, 0, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
